// File: rtl/div_ctrl_if.sv
// Handshake bundle between EX, div_ctrl and the shared radix-2 divider.
// The slave modport is the controller's view; master is the EX/divider side.
interface div_ctrl_if;
   logic        op_valid;
   logic        op_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        stall;
   logic        hilo_we;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        div_valid;
   logic        div_sign;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_ready;
   logic        div_run;
   logic [63:0] div_result;

   modport slave (
      input  op_valid, op_signed, op_a, op_b, flush, div_run, div_result,
      output stall, hilo_we, hi_o, lo_o, div_valid, div_sign, div_a, div_b, div_ready
   );

   modport master (
      output op_valid, op_signed, op_a, op_b, flush, div_run, div_result,
      input  stall, hilo_we, hi_o, lo_o, div_valid, div_sign, div_a, div_b, div_ready
   );
endinterface

// File: rtl/div_ctrl.sv
// Sequences DIV/DIVU through the shared multi-cycle divider: launch, stall EX,
// capture the result into HI/LO, and drain an in-flight divide after a flush.
module div_ctrl (
   input logic       clk,
   input logic       rst,
   div_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, START, BUSY, DONE, DRAIN} state_e;

   state_e      state_q, state_d;
   logic        div_valid_q, div_valid_d;
   logic        div_sign_q, div_sign_d;
   logic [31:0] div_a_q, div_a_d;
   logic [31:0] div_b_q, div_b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        stall;
   logic        hilo_we;
   logic        div_ready;

   always_comb begin
      state_d     = state_q;
      div_valid_d = 1'b0;
      div_sign_d  = div_sign_q;
      div_a_d     = div_a_q;
      div_b_d     = div_b_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      stall       = 1'b0;
      hilo_we     = 1'b0;
      div_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            stall = bus.op_valid & ~bus.flush;
            if (bus.op_valid && !bus.flush) begin
               div_a_d     = bus.op_a;
               div_b_d     = bus.op_b;
               div_sign_d  = bus.op_signed;
               div_valid_d = 1'b1;
               state_d     = START;
            end
         end
         START: begin
            stall   = ~bus.flush;
            state_d = bus.flush ? DRAIN : BUSY;
         end
         BUSY: begin
            stall = ~bus.flush;
            if (bus.div_run) begin
               // The result is always consumed; a flush only suppresses the capture.
               div_ready = 1'b1;
               if (!bus.flush) begin
                  hi_d = bus.div_result[63:32];
                  lo_d = bus.div_result[31:0];
               end
               state_d = bus.flush ? IDLE : DONE;
            end else if (bus.flush) begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            hilo_we = ~bus.flush;
            state_d = IDLE;
         end
         DRAIN: begin
            // The divider cannot be aborted, so a newly presented divide waits here.
            stall     = bus.op_valid;
            div_ready = bus.div_run;
            if (bus.div_run) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         div_valid_q <= 1'b0;
         div_sign_q  <= 1'b0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         state_q     <= state_d;
         div_valid_q <= div_valid_d;
         div_sign_q  <= div_sign_d;
         div_a_q     <= div_a_d;
         div_b_q     <= div_b_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   assign bus.stall     = stall;
   assign bus.hilo_we   = hilo_we;
   assign bus.div_ready = div_ready;
   assign bus.div_valid = div_valid_q;
   assign bus.div_sign  = div_sign_q;
   assign bus.div_a     = div_a_q;
   assign bus.div_b     = div_b_q;
   assign bus.hi_o      = hi_q;
   assign bus.lo_o      = lo_q;

endmodule
